// File: rtl/stw_fault_map_builder_if.sv
// Verdict/control bundle feeding the STW fault map builder.
// The test controller drives it (master); the builder samples it (slave).
interface stw_fault_map_builder_if #(
  parameter int ROWS = 3,
  parameter int COLS = 3
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          start;
  logic          pe_valid;
  logic [RW-1:0] pe_row;
  logic [CW-1:0] pe_col;
  logic          pe_pass;
  logic          pattern_done;

  modport master (
    output start, pe_valid, pe_row, pe_col, pe_pass, pattern_done
  );

  modport slave (
    input start, pe_valid, pe_row, pe_col, pe_pass, pattern_done
  );
endinterface

// File: rtl/stw_fault_map_builder.sv
// Accumulates per-PE pass/fail verdicts over an STW window into a sticky
// fault map (1 = healthy, 0 = faulty) for the recompute controller.
module stw_fault_map_builder #(
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int NUM_RU       = 3,
  parameter int NUM_PATTERNS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  stw_fault_map_builder_if.slave           verdictIf,
  output logic                             STW_result_mat [0:ROWS-1][0:COLS-1],
  output logic                             result_valid,
  output logic                             busy,
  output logic [$clog2(ROWS*COLS+1)-1:0]   fault_count,
  output logic                             over_capacity,
  output logic                             addr_err
);
  localparam int FCW = $clog2(ROWS*COLS+1);
  localparam int PCW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} fsmStateT;

  fsmStateT       state;
  fsmStateT       stateNext;
  logic [PCW-1:0] patternCnt;
  logic           inRange;
  logic           newFault;
  logic           lastPattern;
  logic [FCW-1:0] faultCountNext;

  // A fault only counts on a healthy->faulty transition of its entry.
  always_comb begin
    inRange        = (int'(verdictIf.pe_row) < ROWS) && (int'(verdictIf.pe_col) < COLS);
    newFault       = 1'b0;
    if (inRange) begin
      newFault = verdictIf.pe_valid && !verdictIf.pe_pass &&
                 STW_result_mat[verdictIf.pe_row][verdictIf.pe_col];
    end
    faultCountNext = fault_count + FCW'(newFault);
    lastPattern    = verdictIf.pattern_done && (patternCnt == PCW'(NUM_PATTERNS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (verdictIf.start) begin
      stateNext = COLLECT;
    end else begin
      case (state)
        COLLECT: if (lastPattern) stateNext = DONE;
        default: stateNext = state;
      endcase
    end
  end

  always_comb begin
    busy         = (state == COLLECT);
    result_valid = (state == DONE);
  end

  // start clears the window exactly like reset; only the FSM target differs.
  always_ff @(posedge clk) begin
    if (rst || verdictIf.start) begin
      STW_result_mat <= '{default: 1'b1};
      fault_count    <= '0;
      over_capacity  <= 1'b0;
      addr_err       <= 1'b0;
      patternCnt     <= '0;
    end else if (state == COLLECT) begin
      if (verdictIf.pe_valid) begin
        if (!inRange) begin
          addr_err <= 1'b1;
        end else if (newFault) begin
          STW_result_mat[verdictIf.pe_row][verdictIf.pe_col] <= 1'b0;
          fault_count   <= faultCountNext;
          over_capacity <= (int'(faultCountNext) > NUM_RU);
        end
      end
      if (verdictIf.pattern_done && !lastPattern) begin
        patternCnt <= patternCnt + PCW'(1);
      end
    end
  end
endmodule

// File: doc/stw_fault_map_builder.md
Name: stw_fault_map_builder

Overview:
Producer side of the stop-the-world (STW) fault map. During an STW test window it takes per-PE pass/fail verdicts and accumulates them over NUM_PATTERNS test patterns into a sticky fault matrix. It presents the matrix on STW_result_mat, which feeds directly into recompute_module_controller. Encoding: 1 = PE healthy, 0 = PE faulty.

Parameters:
ROWS, 3, systolic array rows
COLS, 3, systolic array columns
NUM_RU, 3, recompute units available downstream; used only for the capacity flag
NUM_PATTERNS, 4, number of test patterns per STW window (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begin (or restart) an STW window
pe_valid  input  1  verdict strobe
pe_row  input  max(1,$clog2(ROWS))  row index of the verdict
pe_col  input  max(1,$clog2(COLS))  column index of the verdict
pe_pass  input  1  1 = PE output matched golden, 0 = mismatch
pattern_done  input  1  one-cycle pulse; current pattern fully reported
STW_result_mat  output  1 x [0:ROWS-1][0:COLS-1] (unpacked)  sticky fault map
result_valid  output  1  map final and frozen
busy  output  1  window in progress
fault_count  output  $clog2(ROWS*COLS+1)  number of 0 entries in map
over_capacity  output  1  fault_count > NUM_RU
addr_err  output  1  sticky; out-of-range pe_row/pe_col seen this window

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - all STW_result_mat entries = 1
  - result_valid = 0, busy = 0
  - fault_count = 0, over_capacity = 0, addr_err = 0
  - pattern counter = 0, FSM = IDLE
- Reset takes priority over every other input, including mid-window.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - pe_valid and pattern_done are ignored.
  - start -> COLLECT.
- start, accepted in any state:
  - map set to all 1s; fault_count, addr_err and pattern counter cleared; result_valid cleared
  - next state COLLECT, busy = 1 from the following cycle
  - start in COLLECT aborts and restarts the window
  - start in the same cycle as pe_valid or pattern_done: start wins and the other inputs are dropped.
- COLLECT, on pe_valid:
  - In-range index and pe_pass = 0: entry [pe_row][pe_col] becomes 0 on the next edge.
  - fault_count increments only on a 1->0 transition, so repeat failures on the same PE do not double-count.
  - pe_pass = 1 never sets an entry back to 1 (sticky AND).
  - pe_row >= ROWS or pe_col >= COLS: map unchanged, addr_err set.
- COLLECT, on pattern_done:
  - Pattern counter increments.
  - If the counter equals NUM_PATTERNS-1 at that edge: go to DONE, result_valid = 1 and busy = 0 on the next cycle.
  - pe_valid in the same cycle as the final pattern_done is applied before freezing.
- DONE:
  - Map, fault_count and addr_err are frozen; pe_valid and pattern_done are ignored.
  - result_valid stays high until the next start or rst.
- over_capacity = (fault_count > NUM_RU), registered and updated together with fault_count.
- Latency: a verdict becomes visible on STW_result_mat and fault_count one cycle after its pe_valid edge.
- Widths: the counter never overflows, because at most ROWS*COLS faults can be counted.

Test Plan:
- Diagonal faults: rst 3 cycles, start, one pattern with pe_pass=0 at (0,0),(1,1),(2,2) and the rest passing, then 4x pattern_done -> map rows 011/101/110, fault_count=3, over_capacity=0, result_valid=1 exactly one cycle after the 4th pattern_done.
- Sticky and no double count: fail (1,2) in patterns 0 and 2, pass it in patterns 1 and 3 -> map[1][2]=0, fault_count=1.
- Capacity: fail (0,1),(1,0),(2,1),(2,2) -> fault_count=4, over_capacity=1.
- Address error: pe_valid with pe_row=3 and pe_pass=0 -> map all 1s, addr_err=1, fault_count=0.
- Final-pattern collision: pe_valid fail (2,0) in the same cycle as the 4th pattern_done -> map[2][0]=0 in the frozen result. pe_valid fail (0,2) after DONE -> ignored, map[0][2]=1.
- Restart and reset: start mid-COLLECT after 2 faults -> map all 1s, fault_count=0, busy=1. rst mid-window -> all outputs at reset values, and a later pattern_done is ignored (IDLE).
